// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel two-flop synchronizer plus a debounce FSM.
// Produces a registered debounced level, a one-cycle press strobe, and the OR of all strobes.
`default_nettype none

module btn_conditioner #(
   parameter int NB_BUTTONS = 4,
   parameter int NB_DEB_CNT = 16,
   parameter int DEB_CYCLES = 4
) (
   input  logic                  clock,
   input  logic                  i_reset,
   input  logic [NB_BUTTONS-1:0] i_btn,
   output logic [NB_BUTTONS-1:0] o_btn_level,
   output logic [NB_BUTTONS-1:0] o_btn_pulse,
   output logic                  o_any_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_PRESS = 2'd1,
      ST_PRESSED    = 2'd2,
      ST_WAIT_REL   = 2'd3
   } state_e;

   localparam logic [NB_DEB_CNT-1:0] CNT_LAST = NB_DEB_CNT'(DEB_CYCLES - 1);
   localparam logic [NB_DEB_CNT-1:0] CNT_ONE  = NB_DEB_CNT'(1);
   localparam logic [NB_DEB_CNT-1:0] CNT_ZERO = '0;

   logic [NB_BUTTONS-1:0] sync1_q, sync2_q;
   logic [NB_BUTTONS-1:0] level_d, pulse_d;
   logic [NB_BUTTONS-1:0] level_q, pulse_q;
   logic                  any_q;

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
      end
   end

   for (genvar gi = 0; gi < NB_BUTTONS; gi++) begin : g_ch
      state_e                state_q, state_d;
      logic [NB_DEB_CNT-1:0] cnt_q, cnt_d;
      logic                  strobe_d;
      logic                  s;

      assign s = sync2_q[gi];

      always_ff @(posedge clock or negedge i_reset) begin
         if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         strobe_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s) begin
                  state_d = ST_WAIT_PRESS;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d   = CNT_ZERO;
               end
            end
            ST_WAIT_PRESS: begin
               if (!s) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q >= CNT_LAST) begin
                  state_d  = ST_PRESSED;
                  cnt_d    = CNT_ZERO;
                  strobe_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!s) begin
                  state_d = ST_WAIT_REL;
                  cnt_d   = CNT_ONE;
               end
            end
            ST_WAIT_REL: begin
               if (s) begin
                  state_d = ST_PRESSED;
                  cnt_d   = CNT_ZERO;
               end else if (cnt_q >= CNT_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end

      // Level tracks the next state so it changes on the same edge as the FSM.
      assign level_d[gi] = (state_d == ST_PRESSED) || (state_d == ST_WAIT_REL);
      assign pulse_d[gi] = strobe_d;
   end

   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         level_q <= '0;
         pulse_q <= '0;
         any_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         pulse_q <= pulse_d;
         any_q   <= |pulse_d;
      end
   end

   assign o_btn_level = level_q;
   assign o_btn_pulse = pulse_q;
   assign o_any_pulse = any_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table-driven directed vectors plus hand-written reset sequences.
`default_nettype none

module tb_btn_conditioner;

   logic       clock = 1'b0;
   logic       i_reset;
   logic [3:0] i_btn;
   logic [3:0] o_btn_level;
   logic [3:0] o_btn_pulse;
   logic       o_any_pulse;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] lvl;
      logic [3:0] pls;
      logic       any;
   } vec_t;

   vec_t vecs[$];

   btn_conditioner #(
      .NB_BUTTONS(4),
      .NB_DEB_CNT(16),
      .DEB_CYCLES(4)
   ) dut (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_btn      (i_btn),
      .o_btn_level(o_btn_level),
      .o_btn_pulse(o_btn_pulse),
      .o_any_pulse(o_any_pulse)
   );

   always #5 clock = ~clock;

   task automatic add(input int n, input logic [3:0] b, input logic [3:0] l, input logic [3:0] p);
      for (int k = 0; k < n; k++) vecs.push_back('{btn: b, lvl: l, pls: p, any: (p != 4'b0000)});
   endtask

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got lvl/pls/any=%b_%b_%b expected %b_%b_%b at %0t",
                  name, act[8:5], act[4:1], act[0], exp[8:5], exp[4:1], exp[0], $time);
      end
   endtask

   task automatic step(input string name, input logic [3:0] b, input logic [3:0] l, input logic [3:0] p);
      @(negedge clock);
      i_btn = b;
      @(posedge clock);
      #1;
      check(name, {o_btn_level, o_btn_pulse, o_any_pulse}, {l, p, (p != 4'b0000)});
   endtask

   initial begin
      // clean press 0010, held 12 cycles, then release
      add(5, 4'b0010, 4'b0000, 4'b0000);
      add(1, 4'b0010, 4'b0010, 4'b0010);
      add(6, 4'b0010, 4'b0010, 4'b0000);
      add(5, 4'b0000, 4'b0010, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'b0000);
      // glitch: 3 cycles only
      add(3, 4'b0100, 4'b0000, 4'b0000);
      add(5, 4'b0000, 4'b0000, 4'b0000);
      // chord 0011 held 10 cycles, then release
      add(5, 4'b0011, 4'b0000, 4'b0000);
      add(1, 4'b0011, 4'b0011, 4'b0011);
      add(4, 4'b0011, 4'b0011, 4'b0000);
      add(5, 4'b0000, 4'b0011, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'b0000);
      // release bounce on 1000: short release must not drop level or re-pulse
      add(5, 4'b1000, 4'b0000, 4'b0000);
      add(1, 4'b1000, 4'b1000, 4'b1000);
      add(2, 4'b1000, 4'b1000, 4'b0000);
      add(2, 4'b0000, 4'b1000, 4'b0000);
      add(8, 4'b1000, 4'b1000, 4'b0000);
      add(5, 4'b0000, 4'b1000, 4'b0000);
      add(1, 4'b0000, 4'b0000, 4'b0000);
      add(2, 4'b0000, 4'b0000, 4'b0000);

      // reset with all buttons held
      i_reset = 1'b0;
      i_btn   = 4'b1111;
      repeat (3) @(posedge clock);
      #1;
      check("reset_held", {o_btn_level, o_btn_pulse, o_any_pulse}, 9'b0);
      @(negedge clock);
      i_btn = 4'b0000;
      @(posedge clock);
      #1;
      check("reset_idle", {o_btn_level, o_btn_pulse, o_any_pulse}, 9'b0);
      i_reset = 1'b1;
      repeat (2) step("post_reset", 4'b0000, 4'b0000, 4'b0000);

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].btn, vecs[i].lvl, vecs[i].pls);
      end

      // mid-count reset: counting restarts from scratch after release
      repeat (3) step("mid_pre", 4'b0001, 4'b0000, 4'b0000);
      @(negedge clock);
      i_reset = 1'b0;
      #1;
      check("mid_reset", {o_btn_level, o_btn_pulse, o_any_pulse}, 9'b0);
      repeat (2) @(posedge clock);
      #1;
      i_reset = 1'b1;
      for (int k = 1; k <= 5; k++) step($sformatf("mid_wait%0d", k), 4'b0001, 4'b0000, 4'b0000);
      step("mid_pulse", 4'b0001, 4'b0001, 4'b0001);
      step("mid_hold", 4'b0001, 4'b0001, 4'b0000);
      step("mid_hold2", 4'b0001, 4'b0001, 4'b0000);

      // asynchronous reset clears a held level without any clock edge
      @(negedge clock);
      #2;
      i_reset = 1'b0;
      #1;
      check("async_clear", {o_btn_level, o_btn_pulse, o_any_pulse}, 9'b0);
      @(posedge clock);
      #1;
      i_reset = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter NB_BUTTONS, default 4, meaning the number of independent push-button channels.
REQ-002 The block SHALL have parameter NB_DEB_CNT, default 16, meaning the debounce counter width per channel.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 4, meaning the consecutive stable samples required to accept a press or release; legal range 2 to 2^NB_DEB_CNT-1.
REQ-004 The block SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_btn, input, NB_BUTTONS bits: raw, asynchronous, bouncing button inputs.
REQ-007 The block SHALL have port o_btn_level, output, NB_BUTTONS bits: debounced button state, 1 = pressed.
REQ-008 The block SHALL have port o_btn_pulse, output, NB_BUTTONS bits: one-cycle press-accepted strobe per channel, for the downstream LED mode/colour controller.
REQ-009 The block SHALL have port o_any_pulse, output, 1 bit: OR of o_btn_pulse.

Function
REQ-010 Each i_btn bit SHALL pass through a two-flop synchronizer; the second flop output is the sample s; no logic SHALL read i_btn before the first flop.
REQ-011 Each channel SHALL run an independent FSM: IDLE, WAIT_PRESS, PRESSED, WAIT_REL.
REQ-012 In IDLE with s=1: go to WAIT_PRESS, counter=1; with s=0: stay, counter=0.
REQ-013 In WAIT_PRESS with s=0: return to IDLE, counter=0, no pulse.
REQ-014 In WAIT_PRESS with s=1 and counter<DEB_CYCLES-1: counter+1.
REQ-015 In WAIT_PRESS with s=1 and counter=DEB_CYCLES-1: go to PRESSED, counter=0, and o_btn_pulse bit registered high for exactly one cycle.
REQ-016 In PRESSED with s=0: go to WAIT_REL, counter=1; with s=1: stay.
REQ-017 In WAIT_REL, the s=1 return goes to PRESSED, counter=0, no pulse; s=0 counts as in REQ-014, and at DEB_CYCLES-1 goes to IDLE with no pulse.
REQ-018 o_btn_level bit SHALL be 1 in PRESSED and WAIT_REL, 0 in IDLE and WAIT_PRESS, all outputs registered.
REQ-019 Latency: with i_btn bit first sampled 1 at edge 1 and held, o_btn_pulse and o_btn_level SHALL rise after edge DEB_CYCLES+2.
REQ-020 Release latency: o_btn_level SHALL fall after edge DEB_CYCLES+2 counted from the first edge sampling the bit 0.
REQ-021 Counter SHALL never exceed DEB_CYCLES-1 and SHALL NOT wrap.
REQ-022 Simultaneous presses on several channels SHALL produce pulses in the same cycle with no cross-channel interaction.
REQ-023 A held button SHALL produce one pulse only; a new pulse requires passing through IDLE.
REQ-024 o_any_pulse SHALL be registered and coincide with the o_btn_pulse cycle.

Reset
REQ-025 i_reset=0 SHALL immediately clear all synchronizer flops, counters and outputs to 0, and set all FSMs to IDLE, including mid-count.
REQ-026 After i_reset deasserts, a button already held SHALL require full REQ-019 latency before its pulse.

Verification (DEB_CYCLES=4, NB_BUTTONS=4)
REQ-027 Reset: i_reset=0 with i_btn=1111 -> o_btn_level=0000, o_btn_pulse=0000, o_any_pulse=0.
REQ-028 Clean press: i_btn=0010 held 12 cycles -> o_btn_pulse=0010 for exactly one cycle after edge 6, o_any_pulse=1 same cycle, o_btn_level=0010 from edge 6.
REQ-029 Glitch: i_btn=0100 for 3 cycles then 0000 -> o_btn_pulse and o_btn_level stay 0000.
REQ-030 Chord: i_btn=0011 held 10 cycles -> single o_btn_pulse=0011 cycle and o_btn_level=0011.
REQ-031 Release bounce: press 1000 accepted, then 0000 for 2 cycles, then 1000 again -> o_btn_level stays 1000 throughout and no second pulse.
REQ-032 Mid-count reset: i_btn=0001 for 3 cycles, pulse i_reset=0, keep i_btn=0001 -> no pulse until 6 edges after reset release, then one pulse 0001.
